// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ==========================================================================
// mem_bus_pkg : shared types and widths for the native memory-bus arbiter
// Revision    : 1.0
// ==========================================================================
package mem_bus_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_STRB_W = 4;
  localparam int WD_CNT_W   = 8;

  localparam logic [MEM_DATA_W-1:0] DEFAULT_ERR_RDATA = 32'hdeadbeef;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_watchdog.sv
`default_nettype none
// ==========================================================================
// mem_bus_watchdog : counts granted cycles and flags the last allowed cycle
// Revision         : 1.0
// ==========================================================================
module mem_bus_watchdog
  import mem_bus_pkg::*;
#(
  parameter logic [WD_CNT_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam logic [WD_CNT_W-1:0] LIMIT = TIMEOUT_CYCLES - WD_CNT_W'(1);
  localparam logic                ARMED = (TIMEOUT_CYCLES != '0);

  logic [WD_CNT_W-1:0] wd_cnt;

  // A zero timeout pins the counter so the disabled watchdog stays inert.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
    end else if (clear || !ARMED) begin
      wd_cnt <= '0;
    end else if (enable) begin
      wd_cnt <= wd_cnt + WD_CNT_W'(1);
    end
  end

  assign expire = ARMED && enable && (wd_cnt == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_bus_arbiter : two-master round-robin arbiter for a native memory port
// Revision        : 1.0
// ==========================================================================
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter logic [WD_CNT_W-1:0]   TIMEOUT_CYCLES = 8'd255,
  parameter logic [MEM_DATA_W-1:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_mem_valid,
  input  logic                  m0_mem_instr,
  input  logic [MEM_ADDR_W-1:0] m0_mem_addr,
  input  logic [MEM_DATA_W-1:0] m0_mem_wdata,
  input  logic [MEM_STRB_W-1:0] m0_mem_wstrb,
  output logic                  m0_mem_ready,
  output logic [MEM_DATA_W-1:0] m0_mem_rdata,
  input  logic                  m1_mem_valid,
  input  logic                  m1_mem_instr,
  input  logic [MEM_ADDR_W-1:0] m1_mem_addr,
  input  logic [MEM_DATA_W-1:0] m1_mem_wdata,
  input  logic [MEM_STRB_W-1:0] m1_mem_wstrb,
  output logic                  m1_mem_ready,
  output logic [MEM_DATA_W-1:0] m1_mem_rdata,
  output logic                  s_mem_valid,
  output logic                  s_mem_instr,
  output logic [MEM_ADDR_W-1:0] s_mem_addr,
  output logic [MEM_DATA_W-1:0] s_mem_wdata,
  output logic [MEM_STRB_W-1:0] s_mem_wstrb,
  input  logic                  s_mem_ready,
  input  logic [MEM_DATA_W-1:0] s_mem_rdata,
  output logic                  bus_timeout
);

  arb_state_t state;
  logic       last_grant;
  logic       granted_valid;
  logic       wd_expire;
  logic       timeout;
  logic       finish;

  assign granted_valid = ((state == GRANT0) && m0_mem_valid) ||
                         ((state == GRANT1) && m1_mem_valid);
  // A slave answer in the final watchdog cycle wins over the forced completion.
  assign timeout       = wd_expire && !s_mem_ready;
  assign finish        = s_mem_ready || timeout;

  mem_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .enable (granted_valid),
    .clear  (!granted_valid || finish),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_mem_valid && (!m1_mem_valid || last_grant)) begin
            state <= GRANT0;
          end else if (m1_mem_valid) begin
            state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (finish) begin
            state      <= IDLE;
            last_grant <= (state == GRANT1);
          end else if (!granted_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_mem_valid  = 1'b0;
    s_mem_instr  = 1'b0;
    s_mem_addr   = '0;
    s_mem_wdata  = '0;
    s_mem_wstrb  = '0;
    m0_mem_ready = 1'b0;
    m1_mem_ready = 1'b0;
    m0_mem_rdata = '0;
    m1_mem_rdata = '0;
    case (state)
      GRANT0: begin
        s_mem_valid  = m0_mem_valid;
        s_mem_instr  = m0_mem_instr;
        s_mem_addr   = m0_mem_addr;
        s_mem_wdata  = m0_mem_wdata;
        s_mem_wstrb  = m0_mem_wstrb;
        m0_mem_ready = finish;
      end
      GRANT1: begin
        s_mem_valid  = m1_mem_valid;
        s_mem_instr  = m1_mem_instr;
        s_mem_addr   = m1_mem_addr;
        s_mem_wdata  = m1_mem_wdata;
        s_mem_wstrb  = m1_mem_wstrb;
        m1_mem_ready = finish;
      end
      default: ;
    endcase
    if (state != IDLE) begin
      m0_mem_rdata = timeout ? ERR_RDATA : s_mem_rdata;
      m1_mem_rdata = timeout ? ERR_RDATA : s_mem_rdata;
    end
  end

  assign bus_timeout = timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_mem_bus_arbiter : directed bench, watchdog armed (4) and disabled (0)
// Revision           : 1.0
// ==========================================================================
module tb_mem_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        m0_ready, m1_ready, s_valid, s_instr, bus_timeout;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;

  logic        nw_m0_ready, nw_m1_ready, nw_s_valid, nw_s_instr, nw_bus_timeout;
  logic [31:0] nw_m0_rdata, nw_m1_rdata, nw_s_addr, nw_s_wdata;
  logic [3:0]  nw_s_wstrb;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8'd4), .ERR_RDATA(32'hdeadbeef)) dut (
    .clk(clk), .resetn(resetn),
    .m0_mem_valid(m0_valid), .m0_mem_instr(m0_instr), .m0_mem_addr(m0_addr),
    .m0_mem_wdata(m0_wdata), .m0_mem_wstrb(m0_wstrb),
    .m0_mem_ready(m0_ready), .m0_mem_rdata(m0_rdata),
    .m1_mem_valid(m1_valid), .m1_mem_instr(m1_instr), .m1_mem_addr(m1_addr),
    .m1_mem_wdata(m1_wdata), .m1_mem_wstrb(m1_wstrb),
    .m1_mem_ready(m1_ready), .m1_mem_rdata(m1_rdata),
    .s_mem_valid(s_valid), .s_mem_instr(s_instr), .s_mem_addr(s_addr),
    .s_mem_wdata(s_wdata), .s_mem_wstrb(s_wstrb),
    .s_mem_ready(s_ready), .s_mem_rdata(s_rdata), .bus_timeout(bus_timeout)
  );

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8'd0), .ERR_RDATA(32'hdeadbeef)) dut_nowd (
    .clk(clk), .resetn(resetn),
    .m0_mem_valid(m0_valid), .m0_mem_instr(m0_instr), .m0_mem_addr(m0_addr),
    .m0_mem_wdata(m0_wdata), .m0_mem_wstrb(m0_wstrb),
    .m0_mem_ready(nw_m0_ready), .m0_mem_rdata(nw_m0_rdata),
    .m1_mem_valid(m1_valid), .m1_mem_instr(m1_instr), .m1_mem_addr(m1_addr),
    .m1_mem_wdata(m1_wdata), .m1_mem_wstrb(m1_wstrb),
    .m1_mem_ready(nw_m1_ready), .m1_mem_rdata(nw_m1_rdata),
    .s_mem_valid(nw_s_valid), .s_mem_instr(nw_s_instr), .s_mem_addr(nw_s_addr),
    .s_mem_wdata(nw_s_wdata), .s_mem_wstrb(nw_s_wstrb),
    .s_mem_ready(s_ready), .s_mem_rdata(s_rdata), .bus_timeout(nw_bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [5:0] order;
    order    = 6'b101010;
    resetn   = 1'b0;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata  = '0;

    // Reset holds every output low even with live inputs.
    #3; m0_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'h55; #1;
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_timeout", 32'(bus_timeout), 32'd0);
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    tick(); tick(); resetn = 1'b1;

    // Simultaneous requests after reset: m0 first, bubble, then m1.
    m0_addr = 32'h100; m1_addr = 32'h200;
    m1_wdata = 32'h12345678; m1_wstrb = 4'b0011;
    m0_valid = 1'b1; m1_valid = 1'b1; #1;
    chk("tie_idle_s_valid", 32'(s_valid), 32'd0);
    tick(); s_ready = 1'b1; s_rdata = 32'h11; #1;
    chk("tie_g0_addr", s_addr, 32'h100);
    chk("tie_g0_m0_ready", 32'(m0_ready), 32'd1);
    chk("tie_g0_m0_rdata", m0_rdata, 32'h11);
    chk("tie_g0_m1_ready", 32'(m1_ready), 32'd0);
    tick(); m0_valid = 1'b0; s_ready = 1'b0; #1;
    chk("tie_bubble_s_valid", 32'(s_valid), 32'd0);
    tick(); s_ready = 1'b1; s_rdata = 32'h22; #1;
    chk("tie_g1_addr", s_addr, 32'h200);
    chk("tie_g1_m1_ready", 32'(m1_ready), 32'd1);
    chk("tie_g1_m1_rdata", m1_rdata, 32'h22);
    chk("tie_g1_m0_ready", 32'(m0_ready), 32'd0);
    tick(); s_ready = 1'b0; m0_valid = 1'b1; #1;
    chk("rr_idle_s_valid", 32'(s_valid), 32'd0);

    // Continuous requests from both: strict alternation starting with m0.
    for (int i = 0; i < 6; i++) begin
      tick(); s_ready = 1'b1; s_rdata = 32'(i); #1;
      chk("rr_addr", s_addr, order[i] ? 32'h200 : 32'h100);
      chk("rr_m0_ready", 32'(m0_ready), order[i] ? 32'd0 : 32'd1);
      chk("rr_m1_ready", 32'(m1_ready), order[i] ? 32'd1 : 32'd0);
      if (order[i]) begin
        chk("rr_wdata", s_wdata, 32'h12345678);
        chk("rr_wstrb", 32'(s_wstrb), 32'h3);
      end
      tick(); s_ready = 1'b0; #1;
      chk("rr_bubble", 32'(s_valid), 32'd0);
    end
    m0_valid = 1'b0; m1_valid = 1'b0;

    // Slave answers in exactly the 4th granted cycle: real data, no timeout.
    m1_addr = 32'h300; m1_wstrb = 4'b0000; m1_valid = 1'b1;
    tick(); #1;
    chk("wd4_c1_s_valid", 32'(s_valid), 32'd1);
    chk("wd4_c1_m1_ready", 32'(m1_ready), 32'd0);
    tick(); tick(); #1;
    chk("wd4_c3_m1_ready", 32'(m1_ready), 32'd0);
    tick(); s_ready = 1'b1; s_rdata = 32'hcafef00d; #1;
    chk("wd4_c4_m1_ready", 32'(m1_ready), 32'd1);
    chk("wd4_c4_m1_rdata", m1_rdata, 32'hcafef00d);
    chk("wd4_c4_timeout", 32'(bus_timeout), 32'd0);
    tick(); m1_valid = 1'b0; s_ready = 1'b0; #1;
    chk("wd4_done_s_valid", 32'(s_valid), 32'd0);

    // Slave never answers: forced completion in the 4th granted cycle.
    m1_valid = 1'b1;
    tick(); tick(); tick(); #1;
    chk("to_c3_m1_ready", 32'(m1_ready), 32'd0);
    chk("to_c3_timeout", 32'(bus_timeout), 32'd0);
    tick(); #1;
    chk("to_c4_m1_ready", 32'(m1_ready), 32'd1);
    chk("to_c4_m1_rdata", m1_rdata, 32'hdeadbeef);
    chk("to_c4_timeout", 32'(bus_timeout), 32'd1);
    chk("to_c4_m0_ready", 32'(m0_ready), 32'd0);
    chk("nowd_c4_m1_ready", 32'(nw_m1_ready), 32'd0);
    chk("nowd_c4_timeout", 32'(nw_bus_timeout), 32'd0);
    chk("nowd_c4_s_valid", 32'(nw_s_valid), 32'd1);
    tick(); #1;
    chk("to_idle_s_valid", 32'(s_valid), 32'd0);
    chk("to_idle_timeout", 32'(bus_timeout), 32'd0);
    m1_valid = 1'b0;

    // m0 read with a one-cycle slave.
    m0_addr = 32'h000003fc; m0_wstrb = 4'b0000; m0_valid = 1'b1; #1;
    chk("rd_idle_s_valid", 32'(s_valid), 32'd0);
    tick(); #1;
    chk("rd_s_valid", 32'(s_valid), 32'd1);
    chk("rd_s_addr", s_addr, 32'h000003fc);
    chk("rd_wait_m0_ready", 32'(m0_ready), 32'd0);
    tick(); s_ready = 1'b1; s_rdata = 32'h00000005; #1;
    chk("rd_m0_ready", 32'(m0_ready), 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'h00000005);
    chk("rd_m1_ready", 32'(m1_ready), 32'd0);
    tick(); m0_valid = 1'b0; s_ready = 1'b0;

    // Asynchronous reset mid-transaction, then m0 must win a tie again.
    m0_valid = 1'b1;
    tick(); s_ready = 1'b1; s_rdata = 32'h77; #1;
    chk("arst_pre_m0_ready", 32'(m0_ready), 32'd1);
    resetn = 1'b0; #1;
    chk("arst_s_valid", 32'(s_valid), 32'd0);
    chk("arst_m0_ready", 32'(m0_ready), 32'd0);
    chk("arst_m0_rdata", m0_rdata, 32'd0);
    s_ready = 1'b0; m1_valid = 1'b1;
    tick(); resetn = 1'b1; #1;
    chk("arst_rel_s_valid", 32'(s_valid), 32'd0);
    tick(); #1;
    chk("arst_tie_s_valid", 32'(s_valid), 32'd1);
    chk("arst_tie_addr", s_addr, 32'h000003fc);
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
